// File: rtl/qosc_config_loader_pkg.sv
// Shared types and constants for the oscillator configuration loader.
package qosc_config_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int FRAME_LEN   = 11;
    localparam int PAYLOAD_LEN = FRAME_LEN - 1;
    localparam int NUM_WORDS   = PAYLOAD_LEN / 2;

    localparam logic [3:0] IDX_FIRST = 4'd0;
    localparam logic [3:0] IDX_NEXT  = 4'd1;
    localparam logic [3:0] IDX_CSUM  = 4'(FRAME_LEN - 1);

    localparam logic [15:0] DEF_RE  = 16'h7F62;
    localparam logic [15:0] DEF_IM  = 16'h0C8C;
    localparam logic [15:0] DEF_PWR = 16'h4000;
    localparam logic [15:0] DEF_ARE = 16'h4000;
    localparam logic [15:0] DEF_AIM = 16'h0000;

    // Maps an output word index (payload order) onto its reset value.
    function automatic logic [15:0] word_sel(input int idx,
                                             input logic [15:0] w0,
                                             input logic [15:0] w1,
                                             input logic [15:0] w2,
                                             input logic [15:0] w3,
                                             input logic [15:0] w4);
        case (idx)
            0:       return w0;
            1:       return w1;
            2:       return w2;
            3:       return w3;
            default: return w4;
        endcase
    endfunction

endpackage

// File: rtl/qosc_config_loader_cfg_frame_rx.sv
// Frame byte tracker: byte index, running XOR checksum and frame-start restart.
module cfg_frame_rx
    import qosc_config_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic       frame_start,
    input  logic       receiving,
    input  logic [7:0] byte_in,
    output logic       restart,
    output logic       payload_we,
    output logic [3:0] payload_idx,
    output logic       csum_done,
    output logic       csum_match
);

    logic [3:0] idx_reg;
    logic [7:0] xor_reg;
    logic       cont;

    // A frame-start byte always wins, even in the middle of another frame.
    assign restart     = accept && frame_start;
    assign cont        = accept && !frame_start && receiving;
    assign csum_done   = cont && (idx_reg == IDX_CSUM);
    assign payload_we  = restart || (cont && (idx_reg != IDX_CSUM));
    assign payload_idx = restart ? IDX_FIRST : idx_reg;
    assign csum_match  = (xor_reg == byte_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg <= IDX_FIRST;
            xor_reg <= 8'h00;
        end else if (restart) begin
            idx_reg <= IDX_NEXT;
            xor_reg <= byte_in;
        end else if (cont && !csum_done) begin
            idx_reg <= idx_reg + 4'd1;
            xor_reg <= xor_reg ^ byte_in;
        end
    end

endmodule

// File: rtl/qosc_config_loader.sv
// Byte-serial loader for the oscillator configuration: stages an 11-byte frame,
// verifies its XOR checksum and commits all five words atomically.
module qosc_config_loader
    import qosc_config_loader_pkg::*;
#(
    parameter logic [15:0] RE_INIT  = DEF_RE,
    parameter logic [15:0] IM_INIT  = DEF_IM,
    parameter logic [15:0] PWR_INIT = DEF_PWR,
    parameter logic [15:0] ARE_INIT = DEF_ARE,
    parameter logic [15:0] AIM_INIT = DEF_AIM
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        frame_start,
    output logic        byte_ready,
    output logic [15:0] re_coeff,
    output logic [15:0] im_coeff,
    output logic [15:0] power,
    output logic [15:0] accu_re_init,
    output logic [15:0] accu_im_init,
    output logic        load,
    output logic        busy,
    output logic        cfg_error,
    output logic [7:0]  frame_count
);

    state_t      state_reg;
    logic        busy_reg;
    logic        load_reg;
    logic        cfg_error_reg;
    logic [7:0]  frame_count_reg;

    logic        accept;
    logic        restart;
    logic        payload_we;
    logic [3:0]  payload_idx;
    logic        csum_done;
    logic        csum_match;
    logic        commit_go;

    logic [7:0]  stage_bytes [PAYLOAD_LEN];
    logic [15:0] cfg_words   [NUM_WORDS];

    assign byte_ready = (state_reg != ST_COMMIT) && !rst;
    assign accept     = byte_valid && byte_ready;
    assign commit_go  = (state_reg == ST_RECV) && csum_done && csum_match;

    cfg_frame_rx u_rx (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .frame_start (frame_start),
        .receiving   (state_reg == ST_RECV),
        .byte_in     (byte_in),
        .restart     (restart),
        .payload_we  (payload_we),
        .payload_idx (payload_idx),
        .csum_done   (csum_done),
        .csum_match  (csum_match)
    );

    genvar gi;
    generate
        for (gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_stage
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    byte_reg <= 8'h00;
                end else if (payload_we && (payload_idx == 4'(gi))) begin
                    byte_reg <= byte_in;
                end
            end
            assign stage_bytes[gi] = byte_reg;
        end

        // Words are little-endian pairs of staged bytes, all loaded on the same edge.
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_cfg
            localparam logic [15:0] INIT_VAL =
                word_sel(gi, RE_INIT, IM_INIT, PWR_INIT, ARE_INIT, AIM_INIT);
            logic [15:0] word_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= INIT_VAL;
                end else if (commit_go) begin
                    word_reg <= {stage_bytes[2*gi+1], stage_bytes[2*gi]};
                end
            end
            assign cfg_words[gi] = word_reg;
        end
    endgenerate

    // load stays high through reset so the first post-reset cycle preloads defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            busy_reg        <= 1'b0;
            load_reg        <= 1'b1;
            cfg_error_reg   <= 1'b0;
            frame_count_reg <= 8'h00;
        end else begin
            load_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (restart) begin
                        state_reg <= ST_RECV;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (csum_done) begin
                        if (csum_match) begin
                            state_reg       <= ST_COMMIT;
                            load_reg        <= 1'b1;
                            frame_count_reg <= frame_count_reg + 8'd1;
                            cfg_error_reg   <= 1'b0;
                        end else begin
                            state_reg     <= ST_IDLE;
                            busy_reg      <= 1'b0;
                            cfg_error_reg <= 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign re_coeff     = cfg_words[0];
    assign im_coeff     = cfg_words[1];
    assign power        = cfg_words[2];
    assign accu_re_init = cfg_words[3];
    assign accu_im_init = cfg_words[4];
    assign load         = load_reg;
    assign busy         = busy_reg;
    assign cfg_error    = cfg_error_reg;
    assign frame_count  = frame_count_reg;

endmodule
